// File: rtl/uart_tx_word_serializer.sv
// Word FIFO plus LSB-first byte serializer feeding an 8N1 UART transmitter.
// Define UART_SER_HEADER_EN to emit HEADER_BYTE ahead of every word.
module uart_tx_word_serializer #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 4,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         busy
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [BCW-1:0] LAST_BC = BCW'(NB - 1);
  localparam logic [CW-1:0]  FULL    = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, HEADER, SEND} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] sh_next;
  logic [BCW-1:0]        bc;
  logic                  push;
  logic                  pop;

  // Valid/ready: a word moves when in_valid && in_ready, a byte moves when
  // tx_valid && tx_ready; tx_valid/tx_data are registered and hold while stalled.
  assign in_ready   = (count != FULL);
  assign push       = in_valid && in_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign sh_next    = sh >> 8;
  assign fifo_count = count;
  assign busy       = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sh       <= '0;
      bc       <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            sh <= mem[rd_ptr];
            bc <= '0;
`ifdef UART_SER_HEADER_EN
            state <= HEADER;
`else
            state <= SEND;
`endif
          end
        end
`ifdef UART_SER_HEADER_EN
        HEADER: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= HEADER_BYTE;
          end else if (tx_ready) begin
            tx_data <= sh[7:0];
            state   <= SEND;
          end
        end
`endif
        SEND: begin
          // tx_valid is low only on the first cycle after the pop.
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= sh[7:0];
          end else if (tx_ready) begin
            if (bc == LAST_BC) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              sh      <= sh_next;
              bc      <= bc + 1'b1;
              tx_data <= sh_next[7:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
